// File: rtl/ras_recovery.sv
// Back-end shadow of the fetch RAS: logs speculative pops, retires them in order
// with target checking, and replays unretired pops youngest-first after a flush.
package ceres_param;
  localparam int unsigned XLEN = 32;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } ras_t;
endpackage

module ras_recovery
  import ceres_param::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pop_valid_i,
  input  logic [XLEN-1:0]  pop_data_i,
  input  logic             pop_hit_i,
  input  logic             retire_valid_i,
  input  logic [XLEN-1:0]  retire_target_i,
  input  logic             flush_i,
  output ras_t             restore_o,
  output logic             busy_o,
  output logic             mismatch_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_REPLAY} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_data [DEPTH];
  logic              r_hit  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  ras_t              r_restore;
  logic              r_busy;
  logic              r_mismatch;
  logic              r_overflow;

  logic              w_retire;
  logic              w_record;
  logic              w_full;
  logic              w_miss;
  logic [PTR_W-1:0]  w_head_ret;
  logic [PTR_W-1:0]  w_tail_dec;
  logic [CNT_W-1:0]  w_cnt_ret;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  // Retire is resolved first; flush and record then see the post-retire view.
  always_comb begin
    w_retire   = retire_valid_i && (r_count != '0);
    w_head_ret = w_retire ? ptr_inc(r_head) : r_head;
    w_cnt_ret  = w_retire ? r_count - 1'b1 : r_count;
    w_record   = pop_valid_i && !flush_i;
    w_full     = (w_cnt_ret == CNT_W'(DEPTH));
    w_miss     = w_retire && (!r_hit[r_head] || (r_data[r_head] != retire_target_i));
    w_tail_dec = ptr_dec(r_tail);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_restore  <= '0;
      r_busy     <= 1'b0;
      r_mismatch <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_restore.valid <= 1'b0;
          r_busy          <= 1'b0;
          r_mismatch      <= w_miss;
          r_overflow      <= w_record && w_full;
          r_head          <= w_head_ret;
          r_count         <= w_cnt_ret;
          if (flush_i) begin
            // The flush edge already emits the first replay so valid starts next cycle.
            if (w_cnt_ret != '0) begin
              r_mismatch      <= 1'b0;
              r_restore.valid <= 1'b1;
              r_restore.data  <= r_data[w_tail_dec];
              r_tail          <= w_tail_dec;
              r_count         <= w_cnt_ret - 1'b1;
              r_busy          <= 1'b1;
              r_state         <= S_REPLAY;
            end
          end else if (pop_valid_i) begin
            r_data[r_tail] <= pop_data_i;
            r_hit[r_tail]  <= pop_hit_i;
            r_tail         <= ptr_inc(r_tail);
            if (w_full) begin
              r_head <= ptr_inc(w_head_ret);
            end else begin
              r_count <= w_cnt_ret + 1'b1;
            end
          end
        end
        S_REPLAY: begin
          r_mismatch <= 1'b0;
          r_overflow <= 1'b0;
          if (r_count != '0) begin
            r_restore.valid <= 1'b1;
            r_restore.data  <= r_data[w_tail_dec];
            r_tail          <= w_tail_dec;
            r_count         <= r_count - 1'b1;
            r_busy          <= 1'b1;
          end else begin
            r_restore.valid <= 1'b0;
            r_busy          <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign restore_o  = r_restore;
  assign busy_o     = r_busy;
  assign mismatch_o = r_mismatch;
  assign overflow_o = r_overflow;
  assign count_o    = r_count;

endmodule

// File: doc/ras_recovery.md
Name: ras_recovery

Overview:
- Back-end counterpart of the fetch-stage return address stack (RAS). Records every speculative RAS pop issued by fetch.
- Retires those records in order as execute resolves returns, and flags return-target mispredictions.
- On a pipeline flush, replays all unretired popped entries back into the RAS through its restore port, one per cycle, youngest first. The RAS is then restored to its pre-speculation contents.

Parameters:
- DEPTH, 8, maximum number of in-flight (unretired) RAS pops tracked.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.
- XLEN, from ceres_param, data width of return addresses.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- pop_valid_i  input  1  fetch performed a RAS pop this cycle (POP or BOTH operation).
- pop_data_i  input  XLEN  RAS top-of-stack data removed by that pop.
- pop_hit_i  input  1  RAS top-of-stack valid bit at pop time.
- retire_valid_i  input  1  execute resolved the oldest in-flight return, in program order.
- retire_target_i  input  XLEN  actual resolved return target.
- flush_i  input  1  pipeline flush; all unretired pops are speculative and must be undone.
- restore_o  output  ras_t  {valid, data} push into the RAS restore port; registered.
- busy_o  output  1  replay in progress; fetch must stall RAS operations.
- mismatch_o  output  1  one-cycle pulse: a retired prediction was wrong.
- overflow_o  output  1  one-cycle pulse: a pop was recorded while full and the oldest record was dropped.
- count_o  output  CNT_W  current number of in-flight records.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {data, hit}.
  - head = oldest, tail = next free slot, count = occupancy.
  - Pointers wrap modulo DEPTH.
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; head=tail=count=0.
  - restore_o='0, busy_o=0, mismatch_o=0, overflow_o=0.
  - Reset has priority over everything, including a replay in progress.
- FSM states: IDLE, REPLAY.
- IDLE, per cycle, evaluated in this order:
  1. Retire:
     - If retire_valid_i and count>0: remove the head entry.
     - On the next cycle, mismatch_o=1 iff the entry has hit=0 or data != retire_target_i.
     - If retire_valid_i and count==0: ignored, no mismatch. This holds even if a pop is recorded in the same cycle.
  2. Flush:
     - If flush_i: pop_valid_i in that cycle is ignored.
     - If count (after step 1) > 0, go to REPLAY; otherwise stay in IDLE.
  3. Record:
     - If pop_valid_i and no flush: write {pop_data_i, pop_hit_i} at tail.
     - If full after step 1: head advances (oldest dropped), count unchanged, and overflow_o pulses next cycle.
- Simultaneous retire and record with 0<count<=DEPTH: both take effect, count unchanged.
- REPLAY:
  - Each cycle: restore_o.valid=1 on the next cycle, restore_o.data = data of entry tail-1; tail decrements and count decrements.
  - Entries with hit=0 are still replayed, to preserve RAS depth.
  - When count reaches 0, return to IDLE; restore_o.valid drops on the following cycle.
- Latency:
  - Flush asserted in cycle N gives first restore_o.valid in cycle N+1.
  - Exactly K consecutive valid cycles for K entries.
  - busy_o is high from N+1 through N+K, aligned with restore_o.valid.
- During REPLAY, pop_valid_i, retire_valid_i and flush_i are ignored; a re-flush does not restart the replay.
- mismatch_o and overflow_o are registered single-cycle pulses, never high during REPLAY.
- restore_o.valid is 0 whenever not replaying; restore_o.data holds its last value.

Test Plan:
- Reset, then pops of 0x100, 0x200, 0x300 (hit=1), then flush → restore_o.valid for 3 cycles with data 0x300, 0x200, 0x100; busy_o high for those 3 cycles; count_o=0 afterwards.
- Pop 0x100 (hit=1); retire with target 0x100 → no mismatch_o. Pop 0x200; retire with target 0x204 → mismatch_o pulses once.
- Retire with count=0 while a pop of 0x40 occurs in the same cycle → no mismatch_o, count_o=1.
- DEPTH=8: nine pops with data 1..9 → overflow_o pulses on the 9th, count_o=8; flush → replays 9 down to 2.
- Flush with count=0 → no restore_o.valid, busy_o stays 0. Flush with a simultaneous retire of the only entry → no replay.
- Pop entries 0xA, 0xB, then flush; assert rst_i in the second replay cycle → restore_o.valid=0 and count_o=0 on the next cycle. Re-flush during replay has no effect on the sequence.
